// File: rtl/mem_arbiter.sv
// Memory arbiter: the data and instruction cache ports share one RAM command port.
// Data requests win, except that an instruction request passed over once is served next. Every grant is bounded by a timeout.
module mem_arbiter #(
  parameter int TIMEOUT_CYCLES = 64,
  parameter int CNT_W          = 7
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        iREN,
  input  logic [31:0] iaddr,
  output logic [31:0] iload,
  output logic        iwait,
  input  logic        dREN,
  input  logic        dWEN,
  input  logic [31:0] daddr,
  input  logic [31:0] dstore,
  output logic [31:0] dload,
  output logic        dwait,
  output logic        ramREN,
  output logic        ramWEN,
  output logic [31:0] ramaddr,
  output logic [31:0] ramstore,
  input  logic [31:0] ramload,
  input  logic [1:0]  ramstate,
  output logic        memerr
);

  typedef enum logic [1:0] {IDLE, DGRANT, IGRANT} state_t;

  localparam logic [1:0]       RS_ACCESS = 2'd2;
  localparam logic [1:0]       RS_ERROR  = 2'd3;
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(TIMEOUT_CYCLES - 1);

  state_t           r_state;
  logic             r_ifavor;
  logic [CNT_W-1:0] r_cnt;
  logic             r_memerr;

  logic w_dreq;
  logic w_greq;
  logic w_access;
  logic w_done;
  logic w_abort;

  assign w_dreq   = dREN | dWEN;
  assign w_access = (ramstate == RS_ACCESS);
  assign w_greq   = (r_state == DGRANT) ? w_dreq :
                    (r_state == IGRANT) ? iREN   : 1'b0;
  assign w_done   = w_greq & w_access;
  // ACCESS on the expiry cycle is a normal completion, never an abort
  assign w_abort  = w_greq & ~w_access & ((ramstate == RS_ERROR) | (r_cnt == CNT_LAST));
  assign memerr   = r_memerr;

  always_comb begin
    iwait    = 1'b1;
    dwait    = 1'b1;
    ramREN   = 1'b0;
    ramWEN   = 1'b0;
    ramaddr  = 32'h0;
    ramstore = 32'h0;
    iload    = 32'h0;
    dload    = 32'h0;
    case (r_state)
      DGRANT: begin
        ramaddr  = daddr;
        ramstore = dstore;
        ramWEN   = dWEN;
        ramREN   = dREN & ~dWEN;
        dload    = w_abort ? 32'h0 : ramload;
        dwait    = ~(w_done | w_abort);
      end
      IGRANT: begin
        ramaddr = iaddr;
        ramREN  = iREN;
        iload   = w_abort ? 32'h0 : ramload;
        iwait   = ~(w_done | w_abort);
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_state  <= IDLE;
      r_ifavor <= 1'b0;
      r_cnt    <= '0;
      r_memerr <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_cnt <= '0;
          if (w_dreq && iREN && r_ifavor) begin
            r_state  <= IGRANT;
            r_ifavor <= 1'b0;
          end else if (w_dreq) begin
            r_state <= DGRANT;
          end else if (iREN) begin
            r_state <= IGRANT;
          end
        end
        DGRANT, IGRANT: begin
          // An instruction request seen while data holds the port earns the next grant
          if (r_state == DGRANT && iREN)
            r_ifavor <= 1'b1;
          if (!w_greq || w_done || w_abort)
            r_state <= IDLE;
          else
            r_cnt <= r_cnt + CNT_W'(1);
          if (w_abort)
            r_memerr <= 1'b1;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: per-cycle vector table plus hand-written error, withdrawal and async-reset sequences.
module tb_mem_arbiter;

  typedef struct packed {
    logic        iren;
    logic [31:0] iaddr;
    logic        dren;
    logic        dwen;
    logic [31:0] daddr;
    logic [31:0] dstore;
    logic [31:0] rload;
    logic [1:0]  rstate;
  } in_t;

  typedef struct packed {
    logic        iwait;
    logic        dwait;
    logic        rren;
    logic        rwen;
    logic [31:0] raddr;
    logic [31:0] rstore;
    logic [31:0] iload;
    logic [31:0] dload;
    logic        merr;
  } out_t;

  typedef struct {
    string name;
    in_t   i;
    out_t  o;
  } vec_t;

  localparam logic [1:0] FREE = 2'd0, BUSY = 2'd1, ACC = 2'd2, ERR = 2'd3;

  logic        CLK = 1'b0;
  logic        nRST;
  logic        iREN, dREN, dWEN;
  logic [31:0] iaddr, daddr, dstore, ramload;
  logic [1:0]  ramstate;
  logic [31:0] iload, dload, ramaddr, ramstore;
  logic        iwait, dwait, ramREN, ramWEN, memerr;

  int tests  = 0;
  int failed = 0;
  vec_t tbl[$];

  always #5 CLK = ~CLK;

  mem_arbiter #(.TIMEOUT_CYCLES(4), .CNT_W(3)) dut (
    .CLK(CLK), .nRST(nRST),
    .iREN(iREN), .iaddr(iaddr), .iload(iload), .iwait(iwait),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
    .dload(dload), .dwait(dwait),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
    .ramload(ramload), .ramstate(ramstate), .memerr(memerr)
  );

  function automatic in_t mk_in(logic ir, logic [31:0] ia, logic dr, logic dw,
                                logic [31:0] da, logic [31:0] ds,
                                logic [31:0] rl, logic [1:0] rs);
    in_t v;
    v.iren = ir; v.iaddr = ia; v.dren = dr; v.dwen = dw;
    v.daddr = da; v.dstore = ds; v.rload = rl; v.rstate = rs;
    return v;
  endfunction

  function automatic out_t mk_out(logic iw, logic dw, logic rr, logic rw,
                                  logic [31:0] ra, logic [31:0] rs,
                                  logic [31:0] il, logic [31:0] dl, logic me);
    out_t v;
    v.iwait = iw; v.dwait = dw; v.rren = rr; v.rwen = rw;
    v.raddr = ra; v.rstore = rs; v.iload = il; v.dload = dl; v.merr = me;
    return v;
  endfunction

  function automatic out_t idle_o(logic me);
    return mk_out(1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0, me);
  endfunction

  task automatic drive(input in_t v);
    iREN = v.iren; iaddr = v.iaddr; dREN = v.dren; dWEN = v.dwen;
    daddr = v.daddr; dstore = v.dstore; ramload = v.rload; ramstate = v.rstate;
  endtask

  task automatic check(input string nm, input out_t e);
    out_t a;
    a = mk_out(iwait, dwait, ramREN, ramWEN, ramaddr, ramstore, iload, dload, memerr);
    tests++;
    if (a !== e) begin
      failed++;
      $display("FAIL %s: iw/dw/ren/wen=%b%b%b%b addr=%h st=%h il=%h dl=%h me=%b, expected %b%b%b%b addr=%h st=%h il=%h dl=%h me=%b",
               nm, a.iwait, a.dwait, a.rren, a.rwen, a.raddr, a.rstore, a.iload, a.dload, a.merr,
               e.iwait, e.dwait, e.rren, e.rwen, e.raddr, e.rstore, e.iload, e.dload, e.merr);
    end
  endtask

  task automatic apply(input string nm, input in_t i, input out_t e);
    @(negedge CLK);
    drive(i);
    #1;
    check(nm, e);
  endtask

  initial begin
    // D read: BUSY twice then ACCESS
    tbl.push_back('{"idle0",    mk_in(0,0,0,0,0,0,0,FREE), idle_o(0)});
    tbl.push_back('{"drd_req",  mk_in(0,0,1,0,32'h100,0,32'hDEADBEEF,BUSY), idle_o(0)});
    tbl.push_back('{"drd_b1",   mk_in(0,0,1,0,32'h100,0,32'hDEADBEEF,BUSY),
                    mk_out(1,1,1,0,32'h100,0,0,32'hDEADBEEF,0)});
    tbl.push_back('{"drd_b2",   mk_in(0,0,1,0,32'h100,0,32'hDEADBEEF,BUSY),
                    mk_out(1,1,1,0,32'h100,0,0,32'hDEADBEEF,0)});
    tbl.push_back('{"drd_ack",  mk_in(0,0,1,0,32'h100,0,32'hDEADBEEF,ACC),
                    mk_out(1,0,1,0,32'h100,0,0,32'hDEADBEEF,0)});
    tbl.push_back('{"drd_idle", mk_in(0,0,0,0,0,0,0,FREE), idle_o(0)});
    // Simultaneous I/D: D first, then I via fairness flag despite D re-requesting
    tbl.push_back('{"sim_req",  mk_in(1,32'h40,0,1,32'h200,32'h12345678,0,BUSY), idle_o(0)});
    tbl.push_back('{"sim_dwr",  mk_in(1,32'h40,0,1,32'h200,32'h12345678,0,ACC),
                    mk_out(1,0,0,1,32'h200,32'h12345678,0,0,0)});
    tbl.push_back('{"sim_gap",  mk_in(1,32'h40,0,1,32'h200,32'h12345678,0,FREE), idle_o(0)});
    tbl.push_back('{"sim_iack", mk_in(1,32'h40,0,1,32'h200,32'h12345678,32'hCAFEF00D,ACC),
                    mk_out(0,1,1,0,32'h40,0,32'hCAFEF00D,0,0)});
    tbl.push_back('{"sim_dagn", mk_in(0,0,0,1,32'h200,32'h12345678,0,FREE), idle_o(0)});
    // dREN and dWEN together: write wins
    tbl.push_back('{"rw_both",  mk_in(0,0,1,1,32'h300,32'hAA55AA55,32'h5,ACC),
                    mk_out(1,0,0,1,32'h300,32'hAA55AA55,0,32'h5,0)});
    tbl.push_back('{"rw_idle",  mk_in(0,0,0,0,0,0,0,FREE), idle_o(0)});
    // Timeout with TIMEOUT_CYCLES=4: abort on 4th grant cycle
    tbl.push_back('{"to_req",   mk_in(0,0,1,0,32'h500,0,32'h11111111,BUSY), idle_o(0)});
    tbl.push_back('{"to_c0",    mk_in(0,0,1,0,32'h500,0,32'h11111111,BUSY),
                    mk_out(1,1,1,0,32'h500,0,0,32'h11111111,0)});
    tbl.push_back('{"to_c1",    mk_in(0,0,1,0,32'h500,0,32'h11111111,BUSY),
                    mk_out(1,1,1,0,32'h500,0,0,32'h11111111,0)});
    tbl.push_back('{"to_c2",    mk_in(0,0,1,0,32'h500,0,32'h11111111,BUSY),
                    mk_out(1,1,1,0,32'h500,0,0,32'h11111111,0)});
    tbl.push_back('{"to_abort", mk_in(0,0,1,0,32'h500,0,32'h11111111,BUSY),
                    mk_out(1,0,1,0,32'h500,0,0,0,0)});
    tbl.push_back('{"to_err",   mk_in(0,0,0,0,0,0,0,FREE), idle_o(1)});
    // memerr sticky through a good instruction read
    tbl.push_back('{"st_req",   mk_in(1,32'h80,0,0,0,0,0,FREE), idle_o(1)});
    tbl.push_back('{"st_iack",  mk_in(1,32'h80,0,0,0,0,32'h0BADF00D,ACC),
                    mk_out(0,1,1,0,32'h80,0,32'h0BADF00D,0,1)});
    tbl.push_back('{"st_idle",  mk_in(0,0,0,0,0,0,0,FREE), idle_o(1)});

    nRST = 1'b0;
    drive(mk_in(0,0,0,0,0,0,0,FREE));
    #2;
    check("reset", idle_o(0));
    @(negedge CLK);
    nRST = 1'b1;

    foreach (tbl[k]) apply(tbl[k].name, tbl[k].i, tbl[k].o);

    // Reset pulse clears memerr before the error sequence
    @(negedge CLK);
    nRST = 1'b0;
    #1;
    check("rst_clr", idle_o(0));
    @(negedge CLK);
    nRST = 1'b1;

    // ramstate ERROR during IGRANT, then withdrawal mid-grant
    apply("e_req",   mk_in(1,32'h60,0,0,0,0,0,BUSY), idle_o(0));
    apply("e_abort", mk_in(1,32'h60,0,0,0,0,32'h99999999,ERR),
                     mk_out(0,1,1,0,32'h60,0,0,0,0));
    apply("e_idle",  mk_in(1,32'h60,0,0,0,0,0,BUSY), idle_o(1));
    apply("w_grant", mk_in(1,32'h60,0,0,0,0,0,BUSY),
                     mk_out(1,1,1,0,32'h60,0,0,0,1));
    apply("w_drop",  mk_in(0,32'h60,0,0,0,0,0,BUSY),
                     mk_out(1,1,0,0,32'h60,0,0,0,1));
    apply("w_noack", mk_in(0,32'h60,0,0,0,0,0,ACC), idle_o(1));

    // Async reset between edges mid-DGRANT
    apply("r_req",   mk_in(0,0,1,0,32'h700,0,0,BUSY), idle_o(1));
    apply("r_grant", mk_in(0,0,1,0,32'h700,0,0,BUSY),
                     mk_out(1,1,1,0,32'h700,0,0,0,1));
    #2;
    nRST = 1'b0;
    #1;
    check("r_async", idle_o(0));
    @(negedge CLK);
    #1;
    check("r_held", idle_o(0));
    nRST = 1'b1;
    #1;
    check("r_rel", idle_o(0));

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
